// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use and branch-operand stalls, taken-branch/jump
// flushes, and a multi-cycle multiply hold in EX, with a saturating stall-cycle counter.
module hazard_control_unit #(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_Branch,
  input  logic        ID_BranchTaken,
  input  logic        ID_Jump,
  input  logic        EX_MemRead,
  input  logic        EX_RegWrite,
  input  logic        EX_MulOp,
  input  logic [4:0]  EX_WriteReg,
  input  logic [4:0]  MEM_WriteReg,
  input  logic        MEM_MemRead,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        EX_Hold,
  output logic        MulBusy,
  output logic [15:0] StallCycles
);

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

  // The counter is loaded one below the latency: the cycle that enters MUL_WAIT
  // is itself the first cycle of EX occupancy.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  mul_cnt_q, mul_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic match_ex, match_mem;
  logic load_use, br_ex, br_mem, stall;
  logic redirect, hold;

  function automatic logic reads_reg(input logic [4:0] x, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rs,
                                     input logic uses_rt);
    return (x != 5'd0) && ((uses_rs && (rs == x)) || (uses_rt && (rt == x)));
  endfunction

  assign match_ex  = reads_reg(EX_WriteReg, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt);
  assign match_mem = reads_reg(MEM_WriteReg, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt);

  assign load_use = EX_MemRead & match_ex;
  assign br_ex    = ID_Branch & EX_RegWrite & match_ex;
  assign br_mem   = ID_Branch & MEM_MemRead & match_mem;
  assign stall    = load_use | br_ex | br_mem;
  assign redirect = (ID_Branch & ID_BranchTaken) | ID_Jump;

  // EX_MulOp is only looked at in RUN, so it is ignored on the release cycle.
  assign hold = ((state_q == RUN) && EX_MulOp) ||
                ((state_q == MUL_WAIT) && (mul_cnt_q > 4'd1));

  // State register
  // NOTE: reset clears only control state; everything here is plain flops, no memories.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= RUN;
      mul_cnt_q   <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    unique case (state_q)
      RUN: begin
        if (EX_MulOp) begin
          state_d   = MUL_WAIT;
          mul_cnt_d = MUL_LOAD;
        end
      end
      MUL_WAIT: begin
        if (mul_cnt_q > 4'd1) begin
          mul_cnt_d = mul_cnt_q - 4'd1;
        end else begin
          state_d   = RUN;
          mul_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d   = RUN;
        mul_cnt_d = 4'd0;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if (!PCWrite && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Output logic: hold beats data stall, data stall beats flush.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    EX_Hold      = 1'b0;
    MulBusy      = (state_q == MUL_WAIT);
    if (!Reset) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      MulBusy      = 1'b0;
    end else if (hold) begin
      EX_Hold      = 1'b1;
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
    end else if (stall) begin
      // A stalled branch is not resolved, so no flush even if it reads taken.
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (redirect) begin
      IF_ID_Flush  = 1'b1;
    end
  end

  assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit with MUL_LATENCY = 4.
module tb_hazard_control_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg;
  logic        ID_UsesRs, ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump;
  logic        EX_MemRead, EX_RegWrite, EX_MulOp, MEM_MemRead;
  logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, MulBusy;
  logic [15:0] StallCycles;

  int checks = 0;
  int errors = 0;
  int exp_stalls = 0;

  // Control vector order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, MulBusy}
  localparam logic [5:0] C_NORM   = 6'b110000;
  localparam logic [5:0] C_STALL  = 6'b000100;
  localparam logic [5:0] C_FLUSH  = 6'b111000;
  localparam logic [5:0] C_HOLD   = 6'b000010;
  localparam logic [5:0] C_HOLDB  = 6'b000011;
  localparam logic [5:0] C_RST    = 6'b000100;

  wire [5:0] ctl = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, MulBusy};

  hazard_control_unit #(.MUL_LATENCY(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_MulOp(EX_MulOp),
    .EX_WriteReg(EX_WriteReg), .MEM_WriteReg(MEM_WriteReg), .MEM_MemRead(MEM_MemRead),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Bubble(ID_EX_Bubble), .EX_Hold(EX_Hold), .MulBusy(MulBusy),
    .StallCycles(StallCycles)
  );

  always #5 Clock = ~Clock;

  task automatic idle();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
    ID_Branch = 1'b0; ID_BranchTaken = 1'b0; ID_Jump = 1'b0;
    EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_MulOp = 1'b0; EX_WriteReg = 5'd0;
    MEM_WriteReg = 5'd0; MEM_MemRead = 1'b0;
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    idle();
    #1;
    checks++;
    if (ctl !== C_RST) begin
      errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_RST);
    end
    checks++;
    if (StallCycles !== 16'd0) begin
      errors++; $display("FAIL reset_stalls: got %0d expected 0", StallCycles);
    end
    tick();
    checks++;
    if (StallCycles !== 16'd0) begin
      errors++; $display("FAIL reset_hold_stalls: got %0d expected 0", StallCycles);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (ctl !== C_NORM) begin
      errors++; $display("FAIL reset_release_ctl: got %b expected %b", ctl, C_NORM);
    end
    tick();
    exp_stalls = 0;
  endtask

  task automatic test_load_use();
    EX_MemRead = 1'b1; EX_WriteReg = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1'b1;
    #1;
    checks++;
    if (ctl !== C_STALL) begin
      errors++; $display("FAIL load_use_ctl: got %b expected %b", ctl, C_STALL);
    end
    checks++;
    if (StallCycles !== 16'd0) begin
      errors++; $display("FAIL load_use_pre: got %0d expected 0", StallCycles);
    end
    tick();
    exp_stalls++;
    idle();
    #1;
    checks++;
    if (ctl !== C_NORM || StallCycles !== 16'd1) begin
      errors++; $display("FAIL load_use_post: got %b/%0d expected %b/1", ctl, StallCycles, C_NORM);
    end
    // rt match stalls too; an unused rs field never does
    EX_MemRead = 1'b1; EX_WriteReg = 5'd12; ID_Rt = 5'd12; ID_UsesRt = 1'b1;
    #1;
    checks++;
    if (ctl !== C_STALL) begin
      errors++; $display("FAIL load_use_rt: got %b expected %b", ctl, C_STALL);
    end
    tick();
    exp_stalls++;
    idle();
    EX_MemRead = 1'b1; EX_WriteReg = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NORM) begin
      errors++; $display("FAIL load_use_unused_rs: got %b expected %b", ctl, C_NORM);
    end
    tick();
    idle();
  endtask

  task automatic test_reg_zero();
    EX_MemRead = 1'b1; EX_WriteReg = 5'd0; ID_Rs = 5'd0; ID_UsesRs = 1'b1;
    ID_Rt = 5'd0; ID_UsesRt = 1'b1;
    #1;
    checks++;
    if (ctl !== C_NORM) begin
      errors++; $display("FAIL reg_zero_ctl: got %b expected %b", ctl, C_NORM);
    end
    tick();
    idle();
    checks++;
    if (StallCycles !== 16'(exp_stalls)) begin
      errors++; $display("FAIL reg_zero_stalls: got %0d expected %0d", StallCycles, exp_stalls);
    end
  endtask

  task automatic test_branch();
    // Cycle 1: load to $9 in EX, taken branch on $9 in ID -> stall, no flush
    ID_Branch = 1'b1; ID_BranchTaken = 1'b1; ID_Rt = 5'd9; ID_UsesRt = 1'b1;
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd9;
    #1;
    checks++;
    if (ctl !== C_STALL) begin
      errors++; $display("FAIL br_load_ex: got %b expected %b", ctl, C_STALL);
    end
    tick();
    exp_stalls++;
    // Cycle 2: bubble in EX, the load now in MEM
    EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
    MEM_MemRead = 1'b1; MEM_WriteReg = 5'd9;
    #1;
    checks++;
    if (ctl !== C_STALL) begin
      errors++; $display("FAIL br_load_mem: got %b expected %b", ctl, C_STALL);
    end
    tick();
    exp_stalls++;
    // Cycle 3: operand ready, branch resolves taken
    MEM_MemRead = 1'b0; MEM_WriteReg = 5'd0;
    #1;
    checks++;
    if (ctl !== C_FLUSH || StallCycles !== 16'(exp_stalls)) begin
      errors++; $display("FAIL br_flush: got %b/%0d expected %b/%0d", ctl, StallCycles, C_FLUSH, exp_stalls);
    end
    // ALU result in EX also blocks the branch
    EX_RegWrite = 1'b1; EX_WriteReg = 5'd9;
    #1;
    checks++;
    if (ctl !== C_STALL) begin
      errors++; $display("FAIL br_alu_ex: got %b expected %b", ctl, C_STALL);
    end
    tick();
    exp_stalls++;
    // ALU result in MEM is forwardable: no stall; branch not taken -> no flush
    EX_RegWrite = 1'b0; EX_WriteReg = 5'd0; MEM_WriteReg = 5'd9; ID_BranchTaken = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NORM) begin
      errors++; $display("FAIL br_not_taken: got %b expected %b", ctl, C_NORM);
    end
    tick();
    idle();
    ID_Jump = 1'b1;
    #1;
    checks++;
    if (ctl !== C_FLUSH) begin
      errors++; $display("FAIL jump_flush: got %b expected %b", ctl, C_FLUSH);
    end
    tick();
    idle();
  endtask

  task automatic test_multiply();
    logic [5:0] exp_seq [4];
    exp_seq[0] = C_HOLD; exp_seq[1] = C_HOLDB; exp_seq[2] = C_HOLDB; exp_seq[3] = 6'b111001;
    EX_MulOp = 1'b1; ID_Jump = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl !== exp_seq[i]) begin
        errors++; $display("FAIL mul_cycle%0d: got %b expected %b", i, ctl, exp_seq[i]);
      end
      tick();
    end
    exp_stalls += 3;
    EX_MulOp = 1'b0;
    #1;
    checks++;
    if (ctl !== C_FLUSH || StallCycles !== 16'(exp_stalls)) begin
      errors++; $display("FAIL mul_after: got %b/%0d expected %b/%0d", ctl, StallCycles, C_FLUSH, exp_stalls);
    end
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_seq [9];
    exp_seq[0] = C_HOLD;  exp_seq[1] = C_HOLDB; exp_seq[2] = C_HOLDB; exp_seq[3] = 6'b000101;
    exp_seq[4] = C_HOLD;  exp_seq[5] = C_HOLDB; exp_seq[6] = C_HOLDB; exp_seq[7] = 6'b110001;
    exp_seq[8] = C_NORM;
    for (int i = 0; i < 9; i++) begin
      idle();
      EX_MulOp = (i != 8);
      // load-use pattern during a hold must not change outputs; on release it stalls
      if (i == 1 || i == 3) begin
        EX_MemRead = 1'b1; EX_WriteReg = 5'd5; ID_Rs = 5'd5; ID_UsesRs = 1'b1;
      end
      #1;
      checks++;
      if (ctl !== exp_seq[i]) begin
        errors++; $display("FAIL b2b_cycle%0d: got %b expected %b", i, ctl, exp_seq[i]);
      end
      tick();
    end
    exp_stalls += 7;
    idle();
    checks++;
    if (StallCycles !== 16'(exp_stalls)) begin
      errors++; $display("FAIL b2b_stalls: got %0d expected %0d", StallCycles, exp_stalls);
    end
  endtask

  task automatic test_reset_mid_mul();
    EX_MulOp = 1'b1;
    tick();
    tick();
    // Now in MUL_WAIT with MulCnt = 2
    #1;
    checks++;
    if (ctl !== C_HOLDB) begin
      errors++; $display("FAIL rst_mul_pre: got %b expected %b", ctl, C_HOLDB);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (ctl !== C_RST || StallCycles !== 16'd0) begin
      errors++; $display("FAIL rst_mul_now: got %b/%0d expected %b/0", ctl, StallCycles, C_RST);
    end
    EX_MulOp = 1'b0;
    tick();
    Reset = 1'b1;
    #1;
    checks++;
    if (ctl !== C_NORM || StallCycles !== 16'd0) begin
      errors++; $display("FAIL rst_mul_after: got %b/%0d expected %b/0", ctl, StallCycles, C_NORM);
    end
    tick();
    exp_stalls = 0;
  endtask

  task automatic test_saturation();
    EX_MemRead = 1'b1; EX_WriteReg = 5'd3; ID_Rs = 5'd3; ID_UsesRs = 1'b1;
    repeat (65534) @(posedge Clock);
    #1;
    checks++;
    if (StallCycles !== 16'hFFFE) begin
      errors++; $display("FAIL sat_fffe: got %h expected fffe", StallCycles);
    end
    tick();
    checks++;
    if (StallCycles !== 16'hFFFF) begin
      errors++; $display("FAIL sat_ffff: got %h expected ffff", StallCycles);
    end
    repeat (5) @(posedge Clock);
    #1;
    checks++;
    if (StallCycles !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold: got %h expected ffff", StallCycles);
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg_zero();
    test_branch();
    test_multiply();
    test_back_to_back();
    test_reset_mid_mul();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter MUL_LATENCY, default 4, the number of cycles a multiply occupies EX; the legal range is 2..15.
REQ-002 Clock  input  1  single system clock; all state updates on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 ID_Rs, ID_Rt  input  5 each  source register numbers of the instruction in ID.
REQ-005 ID_UsesRs, ID_UsesRt  input  1 each  ID instruction actually reads rs / rt.
REQ-006 ID_Branch, ID_BranchTaken, ID_Jump  input  1 each  ID holds a branch / branch resolves taken / ID holds a jump.
REQ-007 EX_MemRead, EX_RegWrite, EX_MulOp  input  1 each  EX instruction is a load / writes a register / is a multiply.
REQ-008 EX_WriteReg, MEM_WriteReg  input  5 each  destination register of the EX / MEM instruction.
REQ-009 MEM_MemRead  input  1  MEM instruction is a load.
REQ-010 PCWrite, IF_ID_Write  output  1 each  PC update enable / IF-ID register update enable.
REQ-011 IF_ID_Flush, ID_EX_Bubble  output  1 each  squash IF-ID contents / insert a NOP into ID-EX.
REQ-012 EX_Hold, MulBusy  output  1 each  freeze EX and ID-EX / state is MUL_WAIT.
REQ-013 StallCycles  output  16  count of cycles with PCWrite=0.

Function
REQ-014 Match terms: matchX = (ID_UsesRs & ID_Rs==X) | (ID_UsesRt & ID_Rt==X); a match with X==0 never counts.
REQ-015 LoadUse = EX_MemRead & matchEX_WriteReg.
- BrEX = ID_Branch & EX_RegWrite & matchEX_WriteReg.
- BrMEM = ID_Branch & MEM_MemRead & matchMEM_WriteReg.
- Stall = LoadUse | BrEX | BrMEM.
REQ-016 The FSM SHALL have two states: RUN and MUL_WAIT, plus a 4-bit MulCnt.
REQ-017 RUN with EX_MulOp=1:
- Outputs: EX_Hold=1, PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=0, IF_ID_Flush=0.
- Next state: MulCnt<=MUL_LATENCY-1, go to MUL_WAIT.
REQ-018 MUL_WAIT with MulCnt>1:
- Outputs identical to REQ-017.
- MulCnt decrements.
REQ-019 MUL_WAIT with MulCnt==1 (release cycle):
- EX_Hold=0; stall/flush logic per REQ-020..022.
- Next state: RUN, MulCnt<=0.
- EX_MulOp is ignored this cycle.
- Total EX occupancy is exactly MUL_LATENCY cycles; hold is asserted MUL_LATENCY-1 cycles.
REQ-020 No hold and Stall=1: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0 (the branch is not resolved while stalled).
REQ-021 No hold, Stall=0 and ((ID_Branch & ID_BranchTaken) | ID_Jump): IF_ID_Flush=1, PCWrite=1, IF_ID_Write=1.
REQ-022 Otherwise: PCWrite=1, IF_ID_Write=1, all other control outputs 0.
REQ-023 Priority: multiply hold > data stall > flush.
REQ-024 Back-to-back multiplies: a multiply arriving in EX in the cycle after release re-enters MUL_WAIT with no gap cycle.
REQ-025 StallCycles increments on each edge where PCWrite==0 (out of reset); it saturates at 0xFFFF and never wraps.
REQ-026 Hazard outputs are combinational from the current state and inputs; only the state, MulCnt and StallCycles are registered.

Reset
REQ-027 Reset=0 forces state RUN, MulCnt=0 and StallCycles=0 immediately, independent of Clock.
REQ-028 While Reset=0: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Bubble=1, EX_Hold=0, MulBusy=0.
REQ-029 Reset asserted mid-multiply abandons the multiply; after release the block is in RUN with no residual hold.

Verification
REQ-030 Load-use: EX_MemRead=1, EX_WriteReg=8, ID_Rs=8, ID_UsesRs=1 -> one cycle of PCWrite=0, ID_EX_Bubble=1; StallCycles 0->1.
REQ-031 Register zero: same as REQ-030 with EX_WriteReg=0, ID_Rs=0 -> no stall; PCWrite=1.
REQ-032 Branch after load: ID_Branch=1, ID_Rt=9, EX load to $9, next cycle MEM load to $9 -> 2 stall cycles, then IF_ID_Flush=1 once ID_BranchTaken=1.
REQ-033 Multiply, MUL_LATENCY=4: EX_MulOp=1 -> EX_Hold=1 for 3 cycles, MulBusy=1 for 3 cycles; 4th cycle released; a taken jump in ID during the hold flushes only on the release cycle.
REQ-034 Reset during MUL_WAIT (MulCnt=2): outputs immediately take the reset values; after release MulBusy=0, EX_Hold=0, StallCycles=0.
REQ-035 Saturation: force 65536+ consecutive stall cycles -> StallCycles holds 0xFFFF.
